prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 34 +++
 rtl/byte_packer.sv | 39 +++
 rtl/prog_loader.sv | 109 ++++++++++
 tb/tb_prog_loader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and header layout for the boot-time program loader.
// Optional frame checksum enabled by defining PROG_LOADER_CHECKSUM_EN.
package prog_loader_pkg;

  localparam logic [7:0] MAGIC = 8'hA5;

  localparam int MAGIC_LSB = 24;
  localparam int PC_LSB    = 12;
  localparam int PC_W      = 11;
  localparam int N_LSB     = 0;
  localparam int N_W       = 12;

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_HDR, S_LOAD, S_CHK, S_DONE, S_ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_HDR, S_LOAD, S_DONE, S_ERR
  } state_t;
`endif

  function automatic logic hdr_ok(
    input logic [31:0] hdr,
    input int          depth
  );
    logic [N_W-1:0] n;
    n = hdr[N_LSB +: N_W];
    return hdr[MAGIC_LSB +: 8] == MAGIC
        && n != '0
        && 32'(n) <= depth;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Little-endian 4-byte to 32-bit word assembler.
// word_valid pulses for one cycle after the fourth byte.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt;
  logic [23:0] acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      acc        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else if (clear) begin
      cnt        <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (byte_valid) begin
        if (cnt == 2'd3) begin
          word       <= {byte_data, acc};
          word_valid <= 1'b1;
        end else begin
          acc[8*cnt +: 8] <= byte_data;
        end
        cnt <= cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: header, payload into imem, then CPU release.
// Checksum word after payload when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic [ADDR_W-1:0] start_pc,
  output logic              done,
  output logic              err
);

  state_t            state;
  logic [ADDR_W-1:0] wcnt;
  logic [N_W-1:0]    n;
  logic              word_valid;
  logic [31:0]       word;
  logic              take;
  logic              last;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0]       csum;
`endif

  assign in_ready  = !(state == S_DONE || state == S_ERR);
  assign take      = in_valid && in_ready;
  assign last      = 32'(wcnt) == 32'(n) - 32'd1;
  assign mem_wren  = word_valid && state == S_LOAD;
  assign mem_addr  = wcnt;
  assign mem_wdata = word;
  assign cpu_rst_n = state == S_DONE;
  assign done      = state == S_DONE;
  assign err       = state == S_ERR;

  // Leftover bytes are flushed while idle so a reload starts clean
  byte_packer u_pack (
    .clk        (clk),
    .rst        (rst),
    .clear      (!in_ready),
    .byte_valid (take),
    .byte_data  (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_HDR;
      wcnt     <= '0;
      n        <= '0;
      start_pc <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      unique case (state)
        S_HDR: if (word_valid) begin
          if (hdr_ok(word, DEPTH)) begin
            state    <= S_LOAD;
            n        <= word[N_LSB +: N_W];
            start_pc <= word[PC_LSB +: ADDR_W];
            wcnt     <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
          end else begin
            state <= S_ERR;
          end
        end
        S_LOAD: if (word_valid) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          csum <= csum ^ word;
`endif
          // Address holds at N-1 so it never reaches DEPTH
          if (last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state <= S_CHK;
`else
            state <= S_DONE;
`endif
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHK: if (word_valid) begin
          state <= (word == csum) ? S_DONE : S_ERR;
        end
`endif
        S_DONE, S_ERR: if (reload) begin
          state <= S_HDR;
          wcnt  <= '0;
        end
        default: state <= S_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: frame model, write queue, outcome checks.
// Checksum cases run when PROG_LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;

  localparam int ADDR_W = 11;
  localparam int DEPTH  = 2048;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              reload;
  logic              mem_wren;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_rst_n;
  logic [ADDR_W-1:0] start_pc;
  logic              done;
  logic              err;

  prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .reload    (reload),
    .mem_wren  (mem_wren),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst_n (cpu_rst_n),
    .start_pc  (start_pc),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  tests = 0;
  int  fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the oldest expected write
  always @(negedge clk) begin
    if (mem_wren) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr %0d data %h expected none",
                 mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          fails++;
          $display("FAIL write: got addr %0d data %h expected addr %0d data %h",
                   mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps && $urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
  endtask

  task automatic wait_outcome(input bit exp_done, input logic [10:0] pc,
                              input string tag);
    int i;
    i = 0;
    @(negedge clk);
    while (!(done || err) && i < 40) begin
      @(negedge clk);
      i++;
    end
    if (!(done || err)) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no done/err expected one", tag);
    end
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_err"}, 32'(err), 32'(!exp_done));
    chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(exp_done));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    if (exp_done) chk({tag, "_start_pc"}, 32'(start_pc), 32'(pc));
    chk({tag, "_pending_writes"}, 32'(sb.size()), 32'd0);
  endtask

  // Reference: frame accepted iff magic and 1<=N<=DEPTH; word k lands at k
  task automatic run_frame(input logic [31:0] hdr, input logic [31:0] pay[$],
                           input logic [31:0] cs, input bit gaps,
                           input string tag);
    int          n;
    bit          ok;
    bit          exp_done;
    logic [31:0] x;
    n  = int'(hdr[11:0]);
    ok = hdr[31:24] == 8'hA5 && n >= 1 && n <= DEPTH;
    x  = '0;
    if (ok) begin
      for (int k = 0; k < n; k++) begin
        sb.push_back('{addr: 11'(k), data: pay[k]});
        x ^= pay[k];
      end
    end
    send_word(hdr, gaps);
    if (ok) begin
      for (int k = 0; k < n; k++) send_word(pay[k], gaps);
`ifdef PROG_LOADER_CHECKSUM_EN
      send_word(cs, gaps);
      exp_done = cs == x;
`else
      exp_done = 1'b1;
`endif
    end else begin
      exp_done = 1'b0;
    end
    wait_outcome(exp_done, hdr[22:12], tag);
  endtask

  task automatic pulse_reload(input string tag);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload   = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_rl_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
    chk({tag, "_rl_done"}, 32'(done), 32'd0);
    chk({tag, "_rl_err"}, 32'(err), 32'd0);
    chk({tag, "_rl_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_mem_wren"}, 32'(mem_wren), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_start_pc"}, 32'(start_pc), 32'd0);
    chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  function automatic logic [31:0] xor_all(input logic [31:0] p[$]);
    logic [31:0] x;
    x = '0;
    foreach (p[i]) x ^= p[i];
    return x;
  endfunction

  initial begin
    logic [31:0] pay[$];
    logic [31:0] hdr;
    int          n;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    reload   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    reset_check("por");

    pay = '{32'h11111111, 32'h22222222, 32'h33333333};
    run_frame(32'hA5005003, pay, xor_all(pay), 1'b0, "basic");
    pulse_reload("basic");

    pay = '{};
    run_frame(32'h5A000001, pay, 32'd0, 1'b0, "bad_magic");
    pulse_reload("bad_magic");
    run_frame(32'hA5000000, pay, 32'd0, 1'b0, "n_zero");
    pulse_reload("n_zero");
    run_frame(32'hA5000801, pay, 32'd0, 1'b0, "n_2049");
    pulse_reload("n_2049");

`ifdef PROG_LOADER_CHECKSUM_EN
    pay = '{32'h0000000F, 32'h000000F0};
    run_frame(32'hA5001002, pay, 32'h000000FF, 1'b0, "cs_good");
    pulse_reload("cs_good");
    run_frame(32'hA5001002, pay, 32'h000000FE, 1'b0, "cs_bad");
    pulse_reload("cs_bad");
`endif

    // Reset mid payload word 1: only word 0 may have been written
    sb.push_back('{addr: 11'd0, data: 32'hCAFE0000});
    send_word(32'hA5003003, 1'b0);
    send_word(32'hCAFE0000, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    reset_check("midrst");
    chk("midrst_pending_writes", 32'(sb.size()), 32'd0);

    pay = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h0F0F0F0F};
    run_frame(32'hA5007004, pay, xor_all(pay), 1'b0, "after_rst");

    // Bytes offered while done must be ignored
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(negedge clk);
      chk("idle_in_ready", 32'(in_ready), 32'd0);
    end
    pulse_reload("idle");

    for (int f = 0; f < 6; f++) begin
      n   = $urandom_range(1, 8);
      hdr = {8'hA5, 1'b0, 11'($urandom_range(0, 2047)), 12'(n)};
      if ($urandom_range(0, 3) == 0) hdr[31:24] = 8'($urandom_range(0, 255));
      pay = '{};
      for (int k = 0; k < n; k++) pay.push_back($urandom);
      run_frame(hdr, pay, xor_all(pay), 1'b1, "rand");
      pulse_reload("rand");
    end

    pay = '{};
    for (int k = 0; k < DEPTH; k++) pay.push_back($urandom);
    run_frame(32'hA57FF800, pay, xor_all(pay), 1'b0, "n_2048");
    pulse_reload("n_2048");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
